pipe_drain_fifo: RTL
====================

// Module: pipe_drain_fifo
// PURPOSE
//  Consumer end of a fixed-latency signal_pipe datapath. Tracks issue credits
//  for items entering an L-stage pipeline and buffers the items leaving it in a
//  DEPTH-entry FIFO with a valid/ready output. Upstream issues only while
//  issue_ok=1, so results arriving from the pipeline are never dropped.
//  After reset it discards stale data still inside the non-reset delay line.
// PARAMETERS
//  W     32  data width of items leaving the pipeline
//  L     8   latency from issue to in_valid, in cycles (signal_pipe L + 1)
//  DEPTH 16  FIFO entries; power of 2, >= 2; AW = clog2(DEPTH)
// PORTS
//  clk       in   1     rising-edge clock
//  rst       in   1     reset; asynchronous, active-high
//  issue     in   1     upstream launches one item into the pipeline this cycle
//  issue_ok  out  1     credit available; issue is legal only when high
//  in_valid  in   1     item emerging from the pipeline this cycle
//  in_data   in   W     payload of the emerging item
//  out_valid out  1     FIFO head valid
//  out_data  out  W     FIFO head payload
//  out_ready in   1     downstream accepts head when out_valid & out_ready
//  count     out  AW+1  current FIFO occupancy, 0..DEPTH
//  err_issue out  1     sticky: issue seen while issue_ok=0
//  err_ovf   out  1     sticky: in_valid dropped because FIFO full
// BEHAVIOUR
//  Reset (async): state=DRAIN, drain_cnt=0, reserved=0, wr/rd ptr=0, count=0.
//   Outputs: out_valid=0, issue_ok=0, both err=0. Asserting rst mid-operation
//   clears everything immediately; FIFO contents are lost.
//  FSM:
//   DRAIN: in_valid is ignored and issue is treated as illegal. drain_cnt
//    counts cycles after rst deasserts; at drain_cnt=L-1 the next state is RUN.
//    This flushes up to L stale items from the delay line.
//   RUN: normal operation. Leaves RUN only on rst.
//  Credits: reserved = items in flight plus items stored, range 0..DEPTH.
//   issue_ok = (state==RUN) && (reserved != DEPTH); decoded from registers
//    only, with no combinational path from issue or out_ready.
//   pop = out_valid & out_ready. acc_issue = issue & issue_ok.
//   reserved_next = reserved + acc_issue - pop. A simultaneous issue and pop
//    leaves reserved unchanged. Space freed by a pop is visible next cycle.
//   issue & !issue_ok: item not counted; err_issue <= 1 (also in DRAIN).
//  FIFO:
//   Write in RUN when in_valid and (count<DEPTH or pop); stores in_data at
//    wr_ptr, then wr_ptr++ (mod DEPTH wrap).
//   in_valid with count==DEPTH and no pop: item dropped, err_ovf <= 1.
//   out_data = mem[rd_ptr]; out_valid = (count != 0). Pop advances rd_ptr
//    (mod DEPTH wrap). Write and pop in the same cycle: count unchanged.
//   Latency: an item written at edge N appears on out_valid after edge N when
//    the FIFO was empty. There is no same-cycle fall-through.
//   out_data holds while out_valid & !out_ready. Order is strictly FIFO.
//  Error flags clear only on rst.
// TESTING (W=8, L=4, DEPTH=4)
//  Deassert rst, hold in_valid=1 (0xAA) -> issue_ok=0 for 4 cycles, then 1;
//   count stays 0 and out_valid stays 0.
//  4 back-to-back issues, out_ready=0 -> issue_ok=0 after the 4th;
//   in_valid 0x11..0x44 gives count=4, out_data=0x11.
//  reserved=3, issue and pop in the same cycle -> reserved stays 3, issue_ok
//   stays 1, out_data advances to the next item.
//  count=4, in_valid=0x55 with out_ready=1 -> accepted, count=4, then pops
//   return 0x22,0x33,0x44,0x55.
//  count=4, in_valid without pop -> err_ovf=1; issue with issue_ok=0 ->
//   err_issue=1, reserved unchanged; both flags hold until rst.
//  count=3 mid-stream, pulse rst between clock edges -> count=0, out_valid=0,
//   issue_ok=0 before the next edge; drain window restarts.

Source files
------------

// File: rtl/pipe_drain_fifo_if.sv
// Handshake bundle between a fixed-latency pipeline, its issuing upstream, and the drain FIFO.
// The master side drives issue/in_*/out_ready; the slave side (the FIFO) returns credits, head, count and errors.
interface pipe_drain_fifo_if #(
    parameter int W     = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          issue;
    logic          issue_ok;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          err_issue;
    logic          err_ovf;

    modport master (
        output issue, in_valid, in_data, out_ready,
        input  issue_ok, out_valid, out_data, count, err_issue, err_ovf
    );

    modport slave (
        input  issue, in_valid, in_data, out_ready,
        output issue_ok, out_valid, out_data, count, err_issue, err_ovf
    );
endinterface

// File: rtl/pipe_drain_fifo.sv
// Purpose: credit tracker plus output FIFO at the tail of an L-cycle pipeline; flushes stale items after reset.
// Latency: a written item is visible on out_valid one cycle after the write edge (no fall-through).
// Backpressure: out_ready stalls the head; issue_ok drops once in-flight plus stored items reach DEPTH.
module pipe_drain_fifo #(
    parameter int W     = 32,
    parameter int L     = 8,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_drain_fifo_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = (L > 1) ? $clog2(L) : 1;
    localparam logic [AW:0]    FULL     = (AW + 1)'(DEPTH);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(L - 1);

    typedef enum logic {DRAIN, RUN} state_t;

    state_t         state, state_nxt;
    logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
    logic [AW:0]    reserved;
    logic [AW:0]    count;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [W-1:0]   mem [DEPTH];
    logic           err_issue, err_ovf;

    logic run, issue_ok, out_valid, pop, acc_issue, wr_en, ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAIN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Stay in DRAIN for L cycles so items already inside the delay line are discarded.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_nxt = RUN;
                else                         drain_cnt_nxt = drain_cnt + 1'b1;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = DRAIN;
        endcase
    end

    assign run       = (state == RUN);
    assign issue_ok  = run && (reserved != FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && bus.out_ready;
    assign acc_issue = bus.issue && issue_ok;
    assign wr_en     = run && bus.in_valid && ((count != FULL) || pop);
    assign ovf       = run && bus.in_valid && (count == FULL) && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_issue <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (acc_issue && !pop)      reserved <= reserved + 1'b1;
            else if (!acc_issue && pop) reserved <= reserved - 1'b1;

            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;

            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;

            if (bus.issue && !issue_ok) err_issue <= 1'b1;
            if (ovf)                    err_ovf   <= 1'b1;
        end
    end

    // Storage carries no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.issue_ok  = issue_ok;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count;
    assign bus.err_issue = err_issue;
    assign bus.err_ovf   = err_ovf;
endmodule
